pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Hazard scheduler for the 5-stage pipeline, sitting beside the Reg/Dec (ID) stage.
//  Keeps a shadow scoreboard of the destination registers in flight in the EX, MEM and WR stages.
//  From it, drives IF/ID hold, ID/EX bubble, IF/ID flush and the EX-stage forwarding selects.
//  Counts stall and flush cycles for performance debug.
// PARAMETERS
//  CNT_W  16  width of stall_cnt / flush_cnt (saturating)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      async active-low reset
//  id_valid     in   1      IF/ID holds a real instruction
//  id_rs        in   5      Rs field of instruction in ID
//  id_rt        in   5      Rt field of instruction in ID
//  id_use_rs    in   1      ID instruction reads Reg[Rs]
//  id_use_rt    in   1      ID instruction reads Reg[Rt]
//  id_rw        in   5      final write address of ID instruction (after RegDst/Jal mux)
//  id_regwr     in   1      ID instruction writes the regfile
//  id_load      in   1      ID instruction is a load (MemToReg=1)
//  id_jump      in   1      ID instruction is J/Jal/Rtype_J (target known in ID)
//  ex_br_taken  in   1      branch in EX resolved taken this cycle
//  ex_ovf       in   1      overflow in EX; cancels that instruction's write
//  stall_if_id  out  1      hold PC and IF/ID this cycle
//  bubble_ex    out  1      load a NOP into ID/EX at next edge
//  flush_if_id  out  1      clear IF/ID at next edge
//  fwd_a        out  2      EX busA select: 00 regfile, 01 MEM-stage result, 10 WR-stage busW
//  fwd_b        out  2      EX busB select, same encoding
//  state        out  2      00 RUN, 01 STALL, 10 FLUSH (action taken in previous cycle)
//  stall_cnt    out  CNT_W  cycles with stall_if_id=1, saturating at all-ones
//  flush_cnt    out  CNT_W  cycles with flush_if_id=1, saturating at all-ones
// BEHAVIOUR
//  Scoreboard: three entries EX/MEM/WR, each {v, rw[4:0], ld}; reset clears all v=0.
//  - Every edge: WR<=MEM, MEM<=EX (MEM.v cleared if ex_ovf).
//  - EX<={id_valid&id_regwr&(id_rw!=0), id_rw, id_load}.
//  - EX.v is forced to 0 when bubble_ex=1.
//  Match(s, E): E.v && E.rw==s && s!=0; $0 never matches.
//  Load-use (combinational): lu = id_valid & ((id_use_rs & Match(id_rs,EX) & EX.ld) |
//    (id_use_rt & Match(id_rt,EX) & EX.ld)).
//  Outputs (combinational):
//  - stall_if_id = lu & ~ex_br_taken
//  - bubble_ex   = lu | ex_br_taken
//  - flush_if_id = ex_br_taken | (id_valid & id_jump & ~lu)
//  - Priority: ex_br_taken overrides load-use; the ID instruction is discarded, no stall.
//  Forwarding selects: registered, 1-cycle latency; presented while the instruction is in EX.
//  - At an edge with bubble_ex=0: fwd_a <= Match(id_rs,EX)&~EX.ld ? 01 : Match(id_rs,MEM) ? 10 : 00.
//  - EX is checked before MEM, so the youngest writer wins.
//  - fwd_b is computed identically from id_rt.
//  - id_use_* = 0 forces 00.
//  - At an edge with bubble_ex=1: fwd_a/fwd_b <= 00.
//  - ID source matching the WR entry needs no forward: regfile is write-before-read.
//  FSM (state reg, updated every edge):
//  - next = ex_br_taken|flush_if_id ? FLUSH : stall_if_id ? STALL : RUN.
//  - Encoding 11 unused; it recovers to RUN.
//  Counters: stall_cnt += stall_if_id, flush_cnt += flush_if_id; both hold at 2^CNT_W-1.
//  Reset (async, rst_n=0):
//  - scoreboard v=0; fwd_a=fwd_b=00; state=RUN; counters=0.
//  - Comb outputs follow from the cleared scoreboard: stall_if_id=0, bubble_ex=0.
//  - Reset mid-stall drops the stall in the same cycle.
//  Back-to-back loads stall once per dependency; the second cycle sees EX.v=0 (bubble) and
//  the load moved to MEM -> fwd 10.
// TESTING
//  1. lw $8 then add $9,$8,$8 -> 1 cycle stall_if_id=1, bubble_ex=1; next cycle fwd_a=fwd_b=10; stall_cnt=1.
//  2. add $3 then sub $4,$3,$5 -> no stall, fwd_a=01, fwd_b=00 in sub's EX cycle.
//  3. add $3; add $3; or $6,$3 -> fwd_a=01 (youngest wins); a third prior write only -> 10.
//  4. ex_br_taken=1 concurrent with load-use -> stall_if_id=0, bubble_ex=1, flush_if_id=1, state=FLUSH.
//  5. Writes to $0, or ex_ovf on producer -> no match, fwd=00, no stall.
//  6. Assert rst_n low during STALL -> stall drops immediately, counters=0; CNT_W=2 saturates at 3.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard scheduler for a 5-stage pipeline, sitting beside the ID stage.
//   A shadow scoreboard tracks the destination registers in flight. From it
//   the block drives the IF/ID hold, the ID/EX bubble, the IF/ID flush and
//   the registered EX-stage forwarding selects. It also counts stall and
//   flush cycles, saturating at all-ones.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   id_valid          IF/ID holds a real instruction
//   id_rs, id_rt      source register fields of the ID instruction
//   id_use_rs/rt      ID instruction reads Reg[Rs] / Reg[Rt]
//   id_rw             final write address of the ID instruction
//   id_regwr, id_load ID instruction writes the regfile / is a load
//   id_jump           ID instruction is a jump resolved in ID
//   ex_br_taken       branch in EX resolved taken this cycle
//   ex_ovf            overflow in EX, cancels that instruction's write
//   stall_if_id       hold PC and IF/ID this cycle
//   bubble_ex         load a NOP into ID/EX at the next edge
//   flush_if_id       clear IF/ID at the next edge
//   fwd_a, fwd_b      EX operand select: 00 regfile, 01 MEM result, 10 WR busW
//   state             action taken last cycle: 00 RUN, 01 STALL, 10 FLUSH
//   stall_cnt         saturating count of stall_if_id cycles
//   flush_cnt         saturating count of flush_if_id cycles
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       id_rw,
  input  logic             id_regwr,
  input  logic             id_load,
  input  logic             id_jump,
  input  logic             ex_br_taken,
  input  logic             ex_ovf,
  output logic             stall_if_id,
  output logic             bubble_ex,
  output logic             flush_if_id,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_e;

  // Scoreboard. The WR entry is never consulted: the regfile is
  // write-before-read, so a source matching WR needs no forward. Only EX and
  // MEM are held, and only EX needs the load flag (load-use check).
  logic       ex_v_q,   ex_v_d;
  logic [4:0] ex_rw_q,  ex_rw_d;
  logic       ex_ld_q,  ex_ld_d;
  logic       mem_v_q,  mem_v_d;
  logic [4:0] mem_rw_q, mem_rw_d;

  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu;

  // $0 is hard-wired zero, so it never matches a writer.
  function automatic logic sb_match(input logic [4:0] src, input logic v,
                                    input logic [4:0] rw);
    return v && (rw == src) && (src != 5'd0);
  endfunction

  // EX is checked first so the youngest writer wins. A load in EX cannot be
  // forwarded from MEM next cycle; that case is a load-use stall instead.
  function automatic logic [1:0] fwd_sel(input logic use_src, input logic [4:0] src,
                                         input logic ev, input logic [4:0] erw,
                                         input logic eld, input logic mv,
                                         input logic [4:0] mrw);
    if (use_src && sb_match(src, ev, erw) && !eld) return 2'b01;
    if (use_src && sb_match(src, mv, mrw))         return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
    if (en && (cnt != {CNT_W{1'b1}})) return cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    return cnt;
  endfunction

  always_comb begin
    lu = id_valid &
         ((id_use_rs & sb_match(id_rs, ex_v_q, ex_rw_q) & ex_ld_q) |
          (id_use_rt & sb_match(id_rt, ex_v_q, ex_rw_q) & ex_ld_q));

    // A taken branch discards the ID instruction, so it overrides load-use.
    stall_if_id = lu & ~ex_br_taken;
    bubble_ex   = lu | ex_br_taken;
    flush_if_id = ex_br_taken | (id_valid & id_jump & ~lu);

    ex_v_d   = id_valid & id_regwr & (id_rw != 5'd0) & ~bubble_ex;
    ex_rw_d  = id_rw;
    ex_ld_d  = id_load;
    mem_v_d  = ex_v_q & ~ex_ovf;
    mem_rw_d = ex_rw_q;

    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
    if (!bubble_ex) begin
      fwd_a_d = fwd_sel(id_use_rs, id_rs, ex_v_q, ex_rw_q, ex_ld_q, mem_v_q, mem_rw_q);
      fwd_b_d = fwd_sel(id_use_rt, id_rt, ex_v_q, ex_rw_q, ex_ld_q, mem_v_q, mem_rw_q);
    end

    // Next state depends only on this cycle's action, so the unused
    // encoding 11 falls back to RUN on the following edge.
    if (ex_br_taken || flush_if_id) state_d = ST_FLUSH;
    else if (stall_if_id)           state_d = ST_STALL;
    else                            state_d = ST_RUN;

    stall_cnt_d = sat_inc(stall_cnt_q, stall_if_id);
    flush_cnt_d = sat_inc(flush_cnt_q, flush_if_id);
  end

  // Control state: valid bits, selects, FSM and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v_q      <= 1'b0;
      mem_v_q     <= 1'b0;
      fwd_a_q     <= 2'b00;
      fwd_b_q     <= 2'b00;
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_v_q      <= ex_v_d;
      mem_v_q     <= mem_v_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Scoreboard payload: qualified by the valid bits, so no reset needed.
  always_ff @(posedge clk) begin
    ex_rw_q  <= ex_rw_d;
    ex_ld_q  <= ex_ld_d;
    mem_rw_q <= mem_rw_d;
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
